// File: rtl/i2c_rtc_target.sv
// I2C target standing in for a DS-style BCD RTC: seven time registers
// (second..year, index 0..6) behind an auto-incrementing register pointer.
module i2c_rtc_target #(
    parameter logic [6:0]  DEVICE_ADDR     = 7'h68,
    parameter int unsigned MIN_SCL_SAMPLES = 4
) (
    input  logic       clk14,
    input  logic       reset_n,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_o,
    output logic       sda_oen,
    output logic [7:0] ds_second,
    output logic [7:0] ds_minute,
    output logic [7:0] ds_hour,
    output logic [7:0] ds_weekday,
    output logic [7:0] ds_day,
    output logic [7:0] ds_month,
    output logic [7:0] ds_year,
    output logic       wr_strobe,
    output logic [2:0] wr_index,
    output logic       busy
);

    if (MIN_SCL_SAMPLES < 1) begin : g_bad_min_scl
        $error("MIN_SCL_SAMPLES must be at least 1");
    end

    typedef enum logic [3:0] {
        ST_IDLE, ST_ADDR, ST_ADDR_ACK, ST_PTR, ST_PTR_ACK,
        ST_WDATA, ST_WDATA_ACK, ST_RDATA, ST_RMACK, ST_IGNORE
    } state_t;

    state_t      state, state_nxt;
    logic [1:0]  scl_sync, sda_sync;
    logic        scl_prev, sda_prev;
    logic        scl_s, sda_s;
    logic        scl_rise, scl_fall, start_det, stop_det;
    logic [3:0]  bit_cnt, bit_cnt_nxt;
    logic [7:0]  shreg, shreg_nxt;
    logic [2:0]  pointer, pointer_nxt;
    logic        sda_oen_nxt, busy_nxt, wr_en;
    logic [7:0]  regs [0:7];
    logic [7:0]  rd_byte;

    assign scl_s     = scl_sync[1];
    assign sda_s     = sda_sync[1];
    assign scl_rise  = scl_s & ~scl_prev;
    assign scl_fall  = ~scl_s & scl_prev;
    assign start_det = scl_s & scl_prev & sda_prev & ~sda_s;
    assign stop_det  = scl_s & scl_prev & ~sda_prev & sda_s;

    // Entry 7 is never written, so reads of index 7 return 8'h00.
    assign rd_byte = regs[pointer];

    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt;
        shreg_nxt   = shreg;
        pointer_nxt = pointer;
        sda_oen_nxt = sda_oen;
        busy_nxt    = busy;
        wr_en       = 1'b0;
        if (start_det) begin
            state_nxt   = ST_ADDR;
            bit_cnt_nxt = '0;
            sda_oen_nxt = 1'b1;
            busy_nxt    = 1'b0;
        end else if (stop_det) begin
            state_nxt   = ST_IDLE;
            sda_oen_nxt = 1'b1;
            busy_nxt    = 1'b0;
        end else begin
            unique case (state)
                ST_ADDR, ST_PTR, ST_WDATA: begin
                    if (scl_rise) begin
                        shreg_nxt   = {shreg[6:0], sda_s};
                        bit_cnt_nxt = bit_cnt + 4'd1;
                    end else if (scl_fall && bit_cnt == 4'd8) begin
                        bit_cnt_nxt = '0;
                        sda_oen_nxt = 1'b0;
                        if (state == ST_ADDR) begin
                            if (shreg[7:1] == DEVICE_ADDR) begin
                                busy_nxt  = 1'b1;
                                state_nxt = ST_ADDR_ACK;
                            end else begin
                                sda_oen_nxt = 1'b1;
                                state_nxt   = ST_IGNORE;
                            end
                        end else if (state == ST_PTR) begin
                            pointer_nxt = shreg[2:0];
                            state_nxt   = ST_PTR_ACK;
                        end else begin
                            wr_en       = (pointer != 3'd7);
                            pointer_nxt = pointer + 3'd1;
                            state_nxt   = ST_WDATA_ACK;
                        end
                    end
                end
                ST_ADDR_ACK: begin
                    // shreg still holds the address byte; bit 0 is R/W.
                    if (scl_fall) begin
                        if (shreg[0]) begin
                            shreg_nxt   = rd_byte;
                            sda_oen_nxt = rd_byte[7];
                            state_nxt   = ST_RDATA;
                        end else begin
                            sda_oen_nxt = 1'b1;
                            state_nxt   = ST_PTR;
                        end
                    end
                end
                ST_PTR_ACK, ST_WDATA_ACK: begin
                    if (scl_fall) begin
                        sda_oen_nxt = 1'b1;
                        state_nxt   = ST_WDATA;
                    end
                end
                ST_RDATA: begin
                    if (scl_rise) begin
                        bit_cnt_nxt = bit_cnt + 4'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt == 4'd8) begin
                            bit_cnt_nxt = '0;
                            sda_oen_nxt = 1'b1;
                            pointer_nxt = pointer + 3'd1;
                            state_nxt   = ST_RMACK;
                        end else begin
                            shreg_nxt   = {shreg[6:0], 1'b0};
                            sda_oen_nxt = shreg[6];
                        end
                    end
                end
                ST_RMACK: begin
                    // bit_cnt==1 marks an initiator ACK seen on the rising edge.
                    if (scl_rise) begin
                        if (sda_s) begin
                            state_nxt = ST_IGNORE;
                        end else begin
                            bit_cnt_nxt = 4'd1;
                        end
                    end else if (scl_fall && bit_cnt == 4'd1) begin
                        bit_cnt_nxt = '0;
                        shreg_nxt   = rd_byte;
                        sda_oen_nxt = rd_byte[7];
                        state_nxt   = ST_RDATA;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk14 or negedge reset_n) begin
        if (!reset_n) begin
            scl_sync  <= '1;
            sda_sync  <= '1;
            scl_prev  <= 1'b1;
            sda_prev  <= 1'b1;
            state     <= ST_IDLE;
            bit_cnt   <= '0;
            shreg     <= '0;
            pointer   <= '0;
            sda_oen   <= 1'b1;
            busy      <= 1'b0;
            wr_strobe <= 1'b0;
            wr_index  <= '0;
            for (int unsigned i = 0; i < 8; i++) begin
                regs[i] <= '0;
            end
        end else begin
            scl_sync  <= {scl_sync[0], scl_i};
            sda_sync  <= {sda_sync[0], sda_i};
            scl_prev  <= scl_s;
            sda_prev  <= sda_s;
            state     <= state_nxt;
            bit_cnt   <= bit_cnt_nxt;
            shreg     <= shreg_nxt;
            pointer   <= pointer_nxt;
            sda_oen   <= sda_oen_nxt;
            busy      <= busy_nxt;
            wr_strobe <= wr_en;
            if (wr_en) begin
                regs[pointer] <= shreg;
                wr_index      <= pointer;
            end
        end
    end

    assign sda_o      = 1'b0;
    assign ds_second  = regs[0];
    assign ds_minute  = regs[1];
    assign ds_hour    = regs[2];
    assign ds_weekday = regs[3];
    assign ds_day     = regs[4];
    assign ds_month   = regs[5];
    assign ds_year    = regs[6];

endmodule
